// File: rtl/inst_fetch_pkg.sv
// Shared constants, queue entry layout and the static next-PC predictor
// for the instruction fetch stage.
package inst_fetch_pkg;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_WAIT = 2'd1;
  localparam logic [1:0] FS_DROP = 2'd2;

  localparam int ENTRY_W = 96;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  // JAL targets are followed; every other word falls through to pc + 4.
  function automatic logic [31:0] predict_npc(input logic [31:0] pc, input logic [31:0] d);
    logic [31:0] npc;
    if (d[6:0] == OPC_JAL) begin
      npc = pc + {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
    end else begin
      npc = pc + 32'd4;
    end
    return npc;
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Synchronous FIFO holding fetched entries; clear empties it in one cycle
// and takes priority over push and pop.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, single-outstanding request controller, static JAL
// prediction and the instruction queue feeding the decoder.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(QUEUE_DEPTH);

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   npc;
  logic          req_valid;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          clear;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  assign npc        = predict_npc(pc, mem_resp_data);
  assign push       = rdy && !flush && (state == FS_WAIT) && mem_resp_valid;
  assign pop        = rdy && inst_valid && inst_ready && !flush;
  assign clear      = rdy && flush;
  assign push_entry = '{inst: mem_resp_data, pc: pc, pred_pc: npc};

  // A request held across a stall reappears once rdy returns, matching the
  // memory controller that is gated by the same rdy.
  assign mem_req_valid = req_valid && rdy;
  assign inst_valid    = (count != '0);
  assign inst          = head_entry.inst;
  assign inst_pc       = head_entry.pc;
  assign inst_pred_pc  = head_entry.pred_pc;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_data (push_entry),
    .head_data (head_entry),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FS_IDLE;
      pc           <= RESET_PC;
      req_valid    <= 1'b0;
      mem_req_addr <= 32'h0;
    end else if (rdy) begin
      req_valid <= 1'b0;
      if (flush) begin
        pc <= flush_pc;
        // Only a still-unanswered request needs its response dropped later.
        if (((state == FS_WAIT) && !mem_resp_valid) || (state == FS_DROP)) begin
          state <= FS_DROP;
        end else begin
          state <= FS_IDLE;
        end
      end else begin
        case (state)
          FS_IDLE: begin
            if (count < DEPTH_CNT) begin
              req_valid    <= 1'b1;
              mem_req_addr <= pc;
              state        <= FS_WAIT;
            end
          end
          FS_WAIT: begin
            if (mem_resp_valid) begin
              pc    <= npc;
              state <= FS_IDLE;
            end
          end
          FS_DROP: begin
            if (mem_resp_valid) begin
              state <= FS_IDLE;
            end
          end
          default: state <= FS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a hand-driven memory responder and fixed
// expected addresses, PCs and predictions.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pred_pc;
  logic        inst_ready;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  inst_fetch #(
    .QUEUE_DEPTH (16),
    .RESET_PC    (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pred_pc   (inst_pred_pc),
    .inst_ready     (inst_ready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    check(tag, {31'h0, observed}, {31'h0, expected});
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_bit({tag, "_seen"}, mem_req_valid, 1'b1);
    check(tag, mem_req_addr, exp_addr);
  endtask

  task automatic respond(input logic [31:0] data, input int lat);
    repeat (lat) tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
  endtask

  initial begin
    rst            = 1'b1;
    rdy            = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    flush          = 1'b0;
    flush_pc       = 32'h0;
    inst_ready     = 1'b0;
    repeat (2) tick();
    check_bit("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check_bit("rst_inst_valid", inst_valid, 1'b0);

    // Sequential fetch from RESET_PC with a 2-cycle memory.
    rst = 1'b0;
    tick();
    check_bit("req0_valid", mem_req_valid, 1'b1);
    check("req0_addr", mem_req_addr, 32'h0);
    respond(NOP, 2);
    check_bit("head0_valid", inst_valid, 1'b1);
    check("head0_inst", inst, NOP);
    check("head0_pc", inst_pc, 32'h0);
    check("head0_pred", inst_pred_pc, 32'h4);
    check_bit("req1_gap", mem_req_valid, 1'b0);
    tick();
    check_bit("req1_valid", mem_req_valid, 1'b1);
    check("req1_addr", mem_req_addr, 32'h4);
    respond(NOP, 2);
    wait_req("req2", 32'h8);
    respond(32'h0100_006F, 2);
    wait_req("req_jal_fwd", 32'h18);
    respond(NOP, 2);

    // Pop two entries so the JAL sits at the head.
    inst_ready = 1'b1;
    tick();
    check("pop1_pc", inst_pc, 32'h4);
    check("pop1_pred", inst_pred_pc, 32'h8);
    check_bit("req_1c_valid", mem_req_valid, 1'b1);
    check("req_1c_addr", mem_req_addr, 32'h1C);
    tick();
    inst_ready = 1'b0;
    check("jal_inst", inst, 32'h0100_006F);
    check("jal_pc", inst_pc, 32'h8);
    check("jal_pred", inst_pred_pc, 32'h18);

    // Flush while the request to 0x1C is outstanding.
    flush    = 1'b1;
    flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    check_bit("flush_wait_empty", inst_valid, 1'b0);
    check_bit("flush_wait_noreq", mem_req_valid, 1'b0);
    respond(32'h0000_0093, 1);
    check_bit("drop_no_push", inst_valid, 1'b0);
    check_bit("drop_noreq", mem_req_valid, 1'b0);
    tick();
    check_bit("redir_valid", mem_req_valid, 1'b1);
    check("redir_addr", mem_req_addr, 32'h100);

    // Backward JAL: 0x100 - 8.
    respond(32'hFF9F_F06F, 1);
    check("jal_back_pred", inst_pred_pc, 32'hF8);
    wait_req("req_jal_back", 32'hF8);

    // Flush coincident with the response to 0xF8.
    mem_resp_valid = 1'b1;
    mem_resp_data  = NOP;
    flush          = 1'b1;
    flush_pc       = 32'h200;
    tick();
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
    check_bit("coinc_empty", inst_valid, 1'b0);
    check_bit("coinc_noreq", mem_req_valid, 1'b0);
    tick();
    check_bit("coinc_req_valid", mem_req_valid, 1'b1);
    check("coinc_req_addr", mem_req_addr, 32'h200);
    respond(NOP, 1);
    check("coinc_head_pc", inst_pc, 32'h200);

    // Fill the queue to 16 entries.
    for (int i = 1; i < 16; i++) begin
      wait_req("fill_req", 32'h200 + 32'(4 * i));
      respond(NOP, 1);
    end
    for (int i = 0; i < 6; i++) begin
      check_bit("full_noreq", mem_req_valid, 1'b0);
      tick();
    end
    check_bit("full_valid", inst_valid, 1'b1);

    // Drain in PC order; fetching resumes two cycles after the first pop.
    inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_pc", inst_pc, 32'h200 + 32'(4 * i));
      if (i == 2) begin
        check_bit("resume_valid", mem_req_valid, 1'b1);
        check("resume_addr", mem_req_addr, 32'h240);
      end
      tick();
    end
    inst_ready = 1'b0;
    check_bit("drained_empty", inst_valid, 1'b0);

    // Redirect to the top of the address space, then stall mid-WAIT.
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    respond(NOP, 1);
    wait_req("wrap_req", 32'hFFFF_FFFC);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_resp_valid = (i == 2);
      mem_resp_data  = NOP;
      tick();
      check_bit("stall_noreq", mem_req_valid, 1'b0);
      check_bit("stall_empty", inst_valid, 1'b0);
    end
    mem_resp_valid = 1'b0;
    rdy            = 1'b1;
    respond(NOP, 1);
    check("wrap_head_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_head_pred", inst_pred_pc, 32'h0);
    wait_req("wrap_next", 32'h0);

    // Reset while WAIT is pending.
    rst = 1'b1;
    tick();
    check_bit("rst2_req_valid", mem_req_valid, 1'b0);
    check("rst2_req_addr", mem_req_addr, 32'h0);
    check_bit("rst2_inst_valid", inst_valid, 1'b0);
    rst = 1'b0;
    tick();
    check_bit("rst2_req", mem_req_valid, 1'b1);
    check("rst2_addr", mem_req_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
